// File: rtl/dmem_bridge.sv
// dmem_bridge: turns M-stage loads/stores into req/ack data-memory bus
// transactions. It freezes the pipeline with stallM while a transaction is in
// flight, lays store data out on its byte lanes, and forces completion with a
// fault when the bus errors, never answers, or the store pattern is empty.
//
// Handshake: bus_req rises on the edge after an access is accepted and stays
// high, with bus_we/bus_addr/bus_be/bus_wdata held constant, until the first
// cycle in which bus_ack is sampled high. That cycle completes the
// transaction; bus_rdata and bus_err are only looked at in that cycle.
module dmem_bridge #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memreadM,
  input  logic                 memwriteM,
  input  logic [ADDR_SIZE-1:0] aluoutM,
  input  logic [XLEN-1:0]      writedataM,
  input  logic [3:0]           ampM,
  output logic [XLEN-1:0]      readdataM,
  output logic                 stallM,
  output logic                 faultM,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [ADDR_SIZE-1:0] bus_addr,
  output logic [3:0]           bus_be,
  output logic [XLEN-1:0]      bus_wdata,
  input  logic                 bus_ack,
  input  logic [XLEN-1:0]      bus_rdata,
  input  logic                 bus_err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last counter value of a BUSY stretch; reaching it without an ack ends
  // the transaction, which makes bus_req last exactly TIMEOUT cycles.
  localparam logic [7:0] LIMIT     = 8'(TIMEOUT - 1);
  localparam logic [ADDR_SIZE-1:0] WORD_MASK = ~(ADDR_SIZE'(3));

  state_t          state;
  logic [7:0]      count;
  logic            access;
  logic            is_write;
  logic            bad_amp;
  logic            single_byte;
  logic            half_word;
  logic [XLEN-1:0] store_lanes;

  // A simultaneous read and write request is treated as a write.
  assign access   = memreadM | memwriteM;
  assign is_write = memwriteM;
  assign bad_amp  = is_write && (ampM == 4'b0000);

  // Classify the byte-enable pattern to pick the lane replication.
  always_comb begin
    single_byte = 1'b0;
    half_word   = 1'b0;
    case (ampM)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: single_byte = 1'b1;
      4'b0011, 4'b1100:                   half_word   = 1'b1;
      default: begin
        single_byte = 1'b0;
        half_word   = 1'b0;
      end
    endcase
  end

  // Store data arrives right-aligned; copy it onto every lane it may occupy
  // so the memory picks up the right bytes whatever the address offset.
  always_comb begin
    store_lanes = writedataM;
    if (!is_write)
      store_lanes = '0;
    else if (single_byte)
      store_lanes = {4{writedataM[7:0]}};
    else if (half_word)
      store_lanes = {2{writedataM[15:0]}};
  end

  // The pipeline is frozen while an access waits in IDLE and for every BUSY
  // cycle; DONE releases it so the stage advances on the DONE edge.
  always_comb begin
    stallM = 1'b0;
    case (state)
      IDLE:    stallM = access;
      BUSY:    stallM = 1'b1;
      default: stallM = 1'b0;
    endcase
  end

  assign dbg_state = state;

  // Transaction FSM with all bus-facing outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
      readdataM <= '0;
      faultM    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          faultM <= 1'b0;
          if (access) begin
            if (bad_amp) begin
              // Nothing to write: skip the bus and report the fault.
              state  <= DONE;
              faultM <= 1'b1;
            end else begin
              state     <= BUSY;
              count     <= '0;
              bus_req   <= 1'b1;
              bus_we    <= is_write;
              bus_addr  <= aluoutM & WORD_MASK;
              bus_be    <= is_write ? ampM : 4'b1111;
              bus_wdata <= store_lanes;
            end
          end
        end

        BUSY: begin
          if (bus_ack) begin
            // An ack in the limit cycle still counts as a normal completion.
            state   <= DONE;
            bus_req <= 1'b0;
            if (bus_err) begin
              faultM <= 1'b1;
              if (!bus_we)
                readdataM <= '0;
            end else if (!bus_we) begin
              readdataM <= bus_rdata;
            end
          end else if (count == LIMIT) begin
            state   <= DONE;
            bus_req <= 1'b0;
            faultM  <= 1'b1;
            if (!bus_we)
              readdataM <= '0;
          end else begin
            count <= count + 8'd1;
          end
        end

        DONE: begin
          // The fault pulse lasts only this cycle; any new access is looked
          // at afresh in IDLE.
          faultM <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state   <= IDLE;
          bus_req <= 1'b0;
          faultM  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: a table of hand-derived transactions, a reset taken
// in the middle of a transaction, then random transactions predicted by a
// rule-level model of the bridge.
module tb_dmem_bridge;

  localparam int TIMEOUT = 16;

  // Clock / reset block
  logic        clk = 1'b0;
  logic        reset;
  logic        memreadM, memwriteM;
  logic [31:0] aluoutM, writedataM;
  logic [3:0]  ampM;
  logic [31:0] readdataM;
  logic        stallM, faultM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  dmem_bridge #(.XLEN(32), .ADDR_SIZE(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .memreadM(memreadM), .memwriteM(memwriteM),
    .aluoutM(aluoutM), .writedataM(writedataM), .ampM(ampM),
    .readdataM(readdataM), .stallM(stallM), .faultM(faultM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .dbg_state(dbg_state)
  );

  // One transaction: stimulus plus expected observations.
  // n = req cycle in which the bus acks (1 = zero wait), 0 = never.
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  amp;
    int          n;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_we;
    int          e_stall;
    logic        e_fault;
    logic [31:0] e_rdm;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model: expectations from the bridge's rules, not its states.
  function automatic vec_t predict(input vec_t v, input logic [31:0] prev);
    vec_t e;
    bit   acked;
    int   busy;
    e = v;
    e.e_addr = (v.addr / 32'd4) * 32'd4;
    if (v.wr && v.amp == 4'b0000) begin
      e.e_be = 4'b0000; e.e_wdata = 32'h0; e.e_we = 1'b1;
      e.e_stall = 1; e.e_fault = 1'b1; e.e_rdm = prev;
      return e;
    end
    acked = (v.n >= 1) && (v.n <= TIMEOUT);
    busy  = acked ? v.n : TIMEOUT;
    e.e_stall = 1 + busy;
    e.e_we    = v.wr;
    e.e_be    = v.wr ? v.amp : 4'b1111;
    if (!v.wr)
      e.e_wdata = 32'h0;
    else if ($countones(v.amp) == 1)
      e.e_wdata = (v.wd & 32'hFF) * 32'h01010101;
    else if (v.amp == 4'b0011 || v.amp == 4'b1100)
      e.e_wdata = (v.wd & 32'hFFFF) * 32'h00010001;
    else
      e.e_wdata = v.wd;
    e.e_fault = !acked || v.err;
    if (v.wr)
      e.e_rdm = prev;
    else if (acked && !v.err)
      e.e_rdm = v.rdata;
    else
      e.e_rdm = 32'h0;
    return e;
  endfunction

  // Driver + bus responder: starts just after a negedge with the DUT in IDLE,
  // ends just after the negedge of the cycle following DONE.
  task automatic apply_vec(input string tag, input vec_t v);
    int          stall_cnt = 0;
    int          req_cnt   = 0;
    bit          done      = 0;
    bit          stable    = 1;
    logic [31:0] c_addr = 0, c_wdata = 0;
    logic [3:0]  c_be = 0;
    logic        c_we = 0;
    logic        got_fault = 0;
    logic [31:0] got_rdm = 0;
    memreadM = v.rd; memwriteM = v.wr; aluoutM = v.addr;
    writedataM = v.wd; ampM = v.amp;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (stallM) stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          c_addr = bus_addr; c_be = bus_be; c_wdata = bus_wdata; c_we = bus_we;
        end else if (bus_addr !== c_addr || bus_be !== c_be ||
                     bus_wdata !== c_wdata || bus_we !== c_we) begin
          stable = 0;
        end
        bus_ack   = (v.n != 0) && (req_cnt == v.n);
        bus_err   = v.err;
        bus_rdata = v.rdata;
      end else begin
        bus_ack = 1'b0;
        bus_err = 1'b0;
      end
      if (!stallM) begin
        done      = 1;
        got_fault = faultM;
        got_rdm   = readdataM;
        memreadM  = 1'b0;
        memwriteM = 1'b0;
      end
      @(negedge clk);
    end
    bus_ack = 1'b0; bus_err = 1'b0;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".stall"}, 32'(stall_cnt), 32'(v.e_stall));
    check({tag, ".req_cycles"}, 32'(req_cnt), 32'(v.e_stall - 1));
    if (req_cnt > 0) begin
      check({tag, ".addr"}, c_addr, v.e_addr);
      check({tag, ".be"}, 32'(c_be), 32'(v.e_be));
      check({tag, ".wdata"}, c_wdata, v.e_wdata);
      check({tag, ".we"}, 32'(c_we), 32'(v.e_we));
      check({tag, ".stable"}, 32'(stable), 32'd1);
    end
    check({tag, ".fault"}, 32'(got_fault), 32'(v.e_fault));
    check({tag, ".readdata"}, got_rdm, v.e_rdm);
    #1;
    check({tag, ".fault_pulse_end"}, 32'(faultM), 32'd0);
    check({tag, ".idle_req"}, 32'(bus_req), 32'd0);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [3:0] amp, input int n,
                              input logic err, input logic [31:0] rdata,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic e_we, input int e_stall,
                              input logic e_fault, input logic [31:0] e_rdm);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.amp = amp; v.n = n;
    v.err = err; v.rdata = rdata; v.e_addr = e_addr; v.e_be = e_be;
    v.e_wdata = e_wdata; v.e_we = e_we; v.e_stall = e_stall;
    v.e_fault = e_fault; v.e_rdm = e_rdm;
    return v;
  endfunction

  vec_t        tbl[$];
  vec_t        rv;
  logic [31:0] model_rdm;

  initial begin
    // Hand-derived vectors, applied in order (readdataM carries over).
    //           rd wr addr          wd            amp      n   err rdata          e_addr        e_be     e_wdata       we st flt e_rdm
    tbl.push_back(mk(1, 0, 32'h104,  32'h0,        4'b0000, 1,  0, 32'hDEADBEEF, 32'h104,  4'b1111, 32'h0,        0, 2,  0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 32'h203,  32'h000000A5, 4'b1000, 3,  0, 32'h0,        32'h200,  4'b1000, 32'hA5A5A5A5, 1, 4,  0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 32'h012,  32'h1234ABCD, 4'b0011, 2,  0, 32'h0,        32'h010,  4'b0011, 32'hABCDABCD, 1, 3,  0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 32'h3FC,  32'hCAFEF00D, 4'b1111, 1,  0, 32'h0,        32'h3FC,  4'b1111, 32'hCAFEF00D, 1, 2,  0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 32'h021,  32'h00112233, 4'b0110, 1,  0, 32'h0,        32'h020,  4'b0110, 32'h00112233, 1, 2,  0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 32'h040,  32'h0,        4'b0000, 2,  1, 32'h55555555, 32'h040,  4'b1111, 32'h0,        0, 3,  1, 32'h0));
    tbl.push_back(mk(0, 1, 32'h080,  32'h12345678, 4'b0000, 1,  0, 32'h0,        32'h080,  4'b0000, 32'h0,        1, 1,  1, 32'h0));
    tbl.push_back(mk(1, 1, 32'h1001, 32'h00000077, 4'b0100, 1,  0, 32'h0,        32'h1000, 4'b0100, 32'h77777777, 1, 2,  0, 32'h0));
    tbl.push_back(mk(1, 0, 32'h050,  32'h0,        4'b0000, 16, 0, 32'h600DF00D, 32'h050,  4'b1111, 32'h0,        0, 17, 0, 32'h600DF00D));
    tbl.push_back(mk(1, 0, 32'h060,  32'h0,        4'b0000, 0,  0, 32'h0,        32'h060,  4'b1111, 32'h0,        0, 17, 1, 32'h0));
    tbl.push_back(mk(1, 0, 32'h008,  32'h0,        4'b0000, 1,  0, 32'h13579BDF, 32'h008,  4'b1111, 32'h0,        0, 2,  0, 32'h13579BDF));

    reset = 1'b1; memreadM = 0; memwriteM = 0; aluoutM = 0; writedataM = 0;
    ampM = 0; bus_ack = 0; bus_rdata = 0; bus_err = 0;
    repeat (3) @(negedge clk);
    check("rst.bus_req", 32'(bus_req), 0);
    check("rst.bus_we", 32'(bus_we), 0);
    check("rst.stallM", 32'(stallM), 0);
    check("rst.faultM", 32'(faultM), 0);
    check("rst.bus_addr", bus_addr, 0);
    check("rst.bus_be", 32'(bus_be), 0);
    check("rst.bus_wdata", bus_wdata, 0);
    check("rst.readdataM", readdataM, 0);
    check("rst.state", 32'(dbg_state), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++)
      apply_vec($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a load: abandoned silently, then a clean load.
    memreadM = 1; aluoutM = 32'h500; ampM = 0;
    @(negedge clk);
    check("mid_rst.req_before", 32'(bus_req), 1);
    @(negedge clk);
    reset = 1'b1; memreadM = 0;
    @(negedge clk);
    check("mid_rst.req_after", 32'(bus_req), 0);
    check("mid_rst.state", 32'(dbg_state), 0);
    check("mid_rst.fault", 32'(faultM), 0);
    check("mid_rst.stall", 32'(stallM), 0);
    reset = 1'b0;
    @(negedge clk);
    apply_vec("post_rst", mk(1, 0, 32'h504, 0, 0, 1, 0, 32'hA1B2C3D4,
                             32'h504, 4'b1111, 0, 0, 2, 0, 32'hA1B2C3D4));
    model_rdm = 32'hA1B2C3D4;

    // Random transactions against the model.
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind     = $urandom_range(0, 2);
      rv.rd    = (kind != 1);
      rv.wr    = (kind != 0);
      rv.addr  = $urandom;
      rv.wd    = $urandom;
      rv.amp   = 4'($urandom_range(0, 15));
      rv.n     = $urandom_range(0, 18);
      rv.err   = ($urandom_range(0, 3) == 0);
      rv.rdata = $urandom;
      rv = predict(rv, model_rdm);
      model_rdm = rv.e_rdm;
      apply_vec($sformatf("rnd%0d", i), rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Memory-stage companion to the pipelined datapath: sits directly downstream of its M-stage outputs (address, store data, write enable, byte-enable pattern).
- Converts each M-stage load/store into a req/ack transaction on the data-memory bus.
- Freezes the pipeline with `stallM` until the transaction completes.
- Returns the raw 32-bit read word to the datapath's load-extraction muxes. It also aligns store data to byte lanes and times out unresponsive transactions.

Parameters:
- XLEN, 32, data width (fixed 32 in this design).
- ADDR_SIZE, 32, address width.
- TIMEOUT, 16, max BUSY cycles without ack before forced completion; legal 2..255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- memreadM  in  1  M-stage load request.
- memwriteM  in  1  M-stage store request.
- aluoutM  in  ADDR_SIZE  access address.
- writedataM  in  XLEN  store data, unaligned (value in low bits).
- ampM  in  4  store byte-enable pattern.
- readdataM  out  XLEN  completed load word.
- stallM  out  1  pipeline freeze request.
- faultM  out  1  one-cycle fault pulse (timeout, bus error, bad pattern).
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_SIZE  word address (aluoutM with [1:0] forced to 0).
- bus_be  out  4  byte enables.
- bus_wdata  out  XLEN  lane-replicated store data.
- bus_ack  in  1  transaction complete; bus_rdata valid same cycle.
- bus_rdata  in  XLEN  read data.
- bus_err  in  1  error qualifier, sampled only with bus_ack.

Behaviour:
- States: IDLE, BUSY, DONE. Reset (synchronous) forces IDLE.
- Reset values: bus_req, bus_we, faultM, stallM = 0; bus_addr, bus_be, bus_wdata, readdataM = 0; timeout counter = 0.
- Reset asserted mid-BUSY: bus_req drops on the next edge; the transaction is abandoned and no fault is raised.
- access = memreadM | memwriteM. If both are set, the transaction is a write.
- IDLE:
  - stallM = access (combinational).
  - Access with ampM == 0 on a write: no bus cycle; go to DONE with a fault.
  - Any other access: latch we, addr, be, wdata; go to BUSY; counter = 0.
- Latched values:
  - Write: be = ampM.
  - Write, ampM is a single byte: wdata = {4{writedataM[7:0]}}.
  - Write, ampM is 0011 or 1100: wdata = {2{writedataM[15:0]}}.
  - Write, any other ampM: wdata = writedataM.
  - Read: be = 4'b1111; wdata = 0.
- BUSY:
  - bus_req = 1, stallM = 1.
  - bus_we, bus_addr, bus_be and bus_wdata are held stable until the ack cycle.
  - Counter increments every cycle without ack.
  - bus_ack = 1 and bus_err = 0: capture bus_rdata (reads) into readdataM; go to DONE.
  - bus_ack = 1 and bus_err = 1: readdataM = 0; go to DONE with a fault.
  - Counter reaches TIMEOUT-1 with no ack: readdataM = 0; go to DONE with a fault.
  - Ack in the same cycle the counter hits its limit: ack wins, no fault.
- DONE:
  - stallM = 0, bus_req = 0.
  - faultM = 1 for exactly this cycle if the fault flag was set.
  - readdataM is held until the next completed read.
  - The pipeline advances on this edge; next state is IDLE unconditionally.
  - A new M-stage access is therefore evaluated one cycle later, in IDLE.
- Writes leave readdataM unchanged.
- Latency:
  - Minimum: access seen in cycle 0, bus_req in cycle 1, ack in cycle 1, DONE in cycle 2 → 2 stall cycles.
  - Stall cycles = 1 + BUSY cycles.
- No access in IDLE: outputs idle, no bus activity.

Test Plan:
- Load, zero-wait bus: memreadM=1, aluoutM=0x104, bus_ack in the first req cycle with rdata 0xDEADBEEF. Required: bus_addr=0x104, be=1111, we=0; stallM high for 2 cycles; readdataM=0xDEADBEEF in DONE; faultM=0.
- Store byte, 3-cycle ack delay: memwriteM=1, aluoutM=0x203, writedataM=0x000000A5, ampM=1000. Required: bus_addr=0x200, be=1000, wdata=0xA5A5A5A5, stable for 3 req cycles; stall for 4 cycles.
- Timeout, TIMEOUT=16: load with bus_ack never asserted. Required: bus_req high exactly 16 cycles, then DONE with readdataM=0, single-cycle faultM=1, stallM=0.
- Bus error, plus a bad pattern: ack with bus_err=1 → readdataM=0 and faultM pulse. Store with ampM=0000 → no bus_req, stall for 1 cycle, faultM pulse.
- Edge cases:
  - memreadM and memwriteM both set → bus_we=1.
  - Reset asserted during BUSY → bus_req=0 after the next edge and state IDLE; a subsequent load completes normally.
  - Ack coincident with the timeout limit → no fault.
